// File: rtl/gobang_pkg.sv
// Shared constants, FSM state encoding and cursor-direction priority for the GoBang input front end.
package gobang_pkg;

  localparam int BOARD_DIM = 16;
  localparam int COORD_W   = 4;

  // Raw key bit positions inside the five-key vector.
  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_PUT   = 4;

  typedef enum logic [2:0] {
    IDLE,
    CHOICE,
    PUT,
    TURN,
    RELEASE
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  // Only one move per cycle: up > down > left > right.
  function automatic dir_t pick_dir(input logic up, input logic down,
                                    input logic left, input logic right);
    if (up)         return DIR_UP;
    else if (down)  return DIR_DOWN;
    else if (left)  return DIR_LEFT;
    else if (right) return DIR_RIGHT;
    else            return DIR_NONE;
  endfunction

endpackage

// File: rtl/gobang_input_control_if.sv
// Key inputs, datapath strobes and FSM debug state of the GoBang input controller.
// Handshake: strobes are level outputs decoded from registered state; no ready/valid backpressure exists.
interface gobang_input_control_if;
  import gobang_pkg::*;

  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       key_put;
  logic       game_over;
  logic [7:0] coordi;
  logic       put;
  logic       change_able_read;
  logic       turn_control;
  logic       busy;
  state_t     state;

  modport master (
    output key_up, key_down, key_left, key_right, key_put, game_over,
    input  coordi, put, change_able_read, turn_control, busy, state
  );

  modport slave (
    input  key_up, key_down, key_left, key_right, key_put, game_over,
    output coordi, put, change_able_read, turn_control, busy, state
  );

endinterface

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter, debounced level and registered rise pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any sample agreeing with the current level restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gobang_input_control.sv
// GoBang input controller: debounced cursor movement and the choice/put/turn placement sequence.
// Define GOBANG_CURSOR_WRAP_EN to make the cursor wrap modulo 16 instead of saturating.
module gobang_input_control
  import gobang_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PUT_CYCLES      = 2,
  parameter int RESET_ROW       = 7,
  parameter int RESET_COL       = 7
) (
  input logic                   clock,
  input logic                   reset,
  gobang_input_control_if.slave bus
);

  logic [4:0]         raw;
  logic [4:0]         level;
  logic [4:0]         rise;
  logic               unused_levels;
  state_t             state;
  state_t             state_next;
  logic [3:0]         put_cnt;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic               start;

  assign raw = {bus.key_put, bus.key_right, bus.key_left, bus.key_down, bus.key_up};
  assign unused_levels = ^level[3:0];

  for (genvar i = 0; i < 5; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clock (clock),
      .reset (reset),
      .raw   (raw[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  function automatic logic [COORD_W-1:0] step(input logic [COORD_W-1:0] c, input logic inc);
`ifdef GOBANG_CURSOR_WRAP_EN
    return inc ? c + COORD_W'(1) : c - COORD_W'(1);
`else
    if (inc) return (c == COORD_W'(BOARD_DIM - 1)) ? c : c + COORD_W'(1);
    return (c == '0) ? c : c - COORD_W'(1);
`endif
  endfunction

  assign start = rise[K_PUT] && !bus.game_over;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      put_cnt <= '0;
      row     <= COORD_W'(RESET_ROW);
      col     <= COORD_W'(RESET_COL);
    end else begin
      state <= state_next;
      if (state == PUT) put_cnt <= put_cnt + 4'd1;
      else              put_cnt <= '0;
      // A starting placement wins over a same-cycle move; moves are never queued.
      if (state == IDLE && !start) begin
        case (pick_dir(rise[K_UP], rise[K_DOWN], rise[K_LEFT], rise[K_RIGHT]))
          DIR_UP:    row <= step(row, 1'b0);
          DIR_DOWN:  row <= step(row, 1'b1);
          DIR_LEFT:  col <= step(col, 1'b0);
          DIR_RIGHT: col <= step(col, 1'b1);
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CHOICE;
      CHOICE:  state_next = PUT;
      PUT:     if (put_cnt == 4'(PUT_CYCLES - 1)) state_next = TURN;
      TURN:    state_next = RELEASE;
      RELEASE: if (!level[K_PUT]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.coordi           = {row, col};
  assign bus.change_able_read = (state == CHOICE);
  assign bus.put              = (state == PUT);
  assign bus.turn_control     = (state == TURN);
  assign bus.busy             = (state != IDLE);
  assign bus.state            = state;

endmodule

// File: tb/tb_gobang_input_control.sv
// Directed bench for gobang_input_control with DEBOUNCE_CYCLES=4 and PUT_CYCLES=2.
module tb_gobang_input_control;
  import gobang_pkg::*;

  localparam logic [4:0] KU = 5'b00001;
  localparam logic [4:0] KD = 5'b00010;
  localparam logic [4:0] KL = 5'b00100;
  localparam logic [4:0] KR = 5'b01000;
  localparam logic [4:0] KP = 5'b10000;

`ifdef GOBANG_CURSOR_WRAP_EN
  localparam logic [7:0] EXP_EDGE = 8'h7F;
`else
  localparam logic [7:0] EXP_EDGE = 8'h70;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  gobang_input_control_if bus ();

  gobang_input_control #(
    .DEBOUNCE_CYCLES(4),
    .PUT_CYCLES     (2),
    .RESET_ROW      (7),
    .RESET_COL      (7)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_keys(input logic [4:0] v);
    bus.key_up    = v[0];
    bus.key_down  = v[1];
    bus.key_left  = v[2];
    bus.key_right = v[3];
    bus.key_put   = v[4];
  endtask

  task automatic press(input logic [4:0] v, input int hold);
    set_keys(v);
    repeat (hold) tick();
    set_keys(5'b0);
    repeat (10) tick();
  endtask

  task automatic test_reset();
    set_keys(5'b0);
    bus.game_over = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (bus.coordi !== 8'h77) begin
      n_err++; $display("FAIL reset_coordi got=%h exp=77", bus.coordi);
    end
    n_cmp++;
    if ({bus.put, bus.change_able_read, bus.turn_control, bus.busy} !== 4'b0) begin
      n_err++; $display("FAIL reset_strobes got=%b exp=0000",
                        {bus.put, bus.change_able_read, bus.turn_control, bus.busy});
    end
    n_cmp++;
    if (bus.state !== IDLE) begin
      n_err++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, IDLE);
    end
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (bus.coordi !== 8'h77 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset got=%h/%b exp=77/0", bus.coordi, bus.busy);
    end
  endtask

  task automatic test_debounce();
    press(KR, 2);
    n_cmp++;
    if (bus.coordi !== 8'h77) begin
      n_err++; $display("FAIL glitch_no_move got=%h exp=77", bus.coordi);
    end
    press(KR, 10);
    n_cmp++;
    if (bus.coordi !== 8'h78) begin
      n_err++; $display("FAIL held_right_once got=%h exp=78", bus.coordi);
    end
  endtask

  task automatic test_edge();
    repeat (8) press(KL, 8);
    n_cmp++;
    if (bus.coordi !== 8'h70) begin
      n_err++; $display("FAIL walk_to_col0 got=%h exp=70", bus.coordi);
    end
    press(KL, 8);
    n_cmp++;
    if (bus.coordi !== EXP_EDGE) begin
      n_err++; $display("FAIL left_at_edge got=%h exp=%h", bus.coordi, EXP_EDGE);
    end
  endtask

  task automatic test_put_sequence();
    int t = 0;
    set_keys(KP);
    while (bus.change_able_read !== 1'b1 && t < 30) begin
      tick(); t++;
    end
    n_cmp++;
    if (t >= 30) begin
      n_err++; $display("FAIL choice_timeout got=%0d exp<30", t);
    end else begin
      n_cmp++;
      if ({bus.change_able_read, bus.put, bus.turn_control, bus.busy} !== 4'b1001) begin
        n_err++; $display("FAIL cycle_n1 got=%b exp=1001",
                          {bus.change_able_read, bus.put, bus.turn_control, bus.busy});
      end
      tick();
      n_cmp++;
      if ({bus.change_able_read, bus.put, bus.turn_control} !== 3'b010) begin
        n_err++; $display("FAIL cycle_n2 got=%b exp=010",
                          {bus.change_able_read, bus.put, bus.turn_control});
      end
      tick();
      n_cmp++;
      if ({bus.change_able_read, bus.put, bus.turn_control} !== 3'b010) begin
        n_err++; $display("FAIL cycle_n3 got=%b exp=010",
                          {bus.change_able_read, bus.put, bus.turn_control});
      end
      tick();
      n_cmp++;
      if ({bus.change_able_read, bus.put, bus.turn_control} !== 3'b001) begin
        n_err++; $display("FAIL cycle_n4 got=%b exp=001",
                          {bus.change_able_read, bus.put, bus.turn_control});
      end
      repeat (4) tick();
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.state !== RELEASE || bus.turn_control !== 1'b0) begin
        n_err++; $display("FAIL hold_release got=%b/%0d exp=1/%0d", bus.busy, bus.state, RELEASE);
      end
    end
    set_keys(5'b0);
    tick();
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL busy_after_raw_release got=%b exp=1", bus.busy);
    end
    t = 0;
    while (bus.busy !== 1'b0 && t < 30) begin
      tick(); t++;
    end
    n_cmp++;
    if (t >= 30) begin
      n_err++; $display("FAIL idle_timeout got=%0d exp<30", t);
    end
    n_cmp++;
    if (bus.coordi !== EXP_EDGE) begin
      n_err++; $display("FAIL coordi_frozen got=%h exp=%h", bus.coordi, EXP_EDGE);
    end
    repeat (4) tick();
  endtask

  task automatic test_game_over();
    bus.game_over = 1'b1;
    set_keys(KP);
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if ({bus.change_able_read, bus.put, bus.turn_control, bus.busy} !== 4'b0) begin
        n_err++; $display("FAIL game_over_put cyc=%0d got=%b exp=0000", i,
                          {bus.change_able_read, bus.put, bus.turn_control, bus.busy});
      end
    end
    set_keys(5'b0);
    repeat (10) tick();
    press(KD, 8);
    n_cmp++;
    if (bus.coordi !== EXP_EDGE + 8'h10) begin
      n_err++; $display("FAIL game_over_move got=%h exp=%h", bus.coordi, EXP_EDGE + 8'h10);
    end
    bus.game_over = 1'b0;
  endtask

  task automatic test_reset_mid_put();
    int t = 0;
    set_keys(KP);
    while (bus.put !== 1'b1 && t < 30) begin
      tick(); t++;
    end
    n_cmp++;
    if (t >= 30) begin
      n_err++; $display("FAIL put_timeout got=%0d exp<30", t);
    end
    reset = 1'b1;
    set_keys(5'b0);
    tick();
    n_cmp++;
    if (bus.put !== 1'b0 || bus.busy !== 1'b0 || bus.state !== IDLE) begin
      n_err++; $display("FAIL reset_mid_put got=%b/%b/%0d exp=0/0/%0d",
                        bus.put, bus.busy, bus.state, IDLE);
    end
    n_cmp++;
    if (bus.coordi !== 8'h77) begin
      n_err++; $display("FAIL reset_mid_put_coordi got=%h exp=77", bus.coordi);
    end
    reset = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL no_spurious_start got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    press(KU | KL, 8);
    n_cmp++;
    if (bus.coordi !== 8'h67) begin
      n_err++; $display("FAIL up_left_priority got=%h exp=67", bus.coordi);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_edge();
    test_put_sequence();
    test_game_over();
    test_reset_mid_put();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
